// File: rtl/instr_exec_sequencer.sv
// instr_exec_sequencer
// Walks an inclusive, wrap-around address range of the instruction register. For each entry it
// fetches {opcode, op_a, op_b} and issues it to the shared signed ALU over a valid/ready
// handshake. The low 32 bits of the result are written back to the same entry. Divide-by-zero
// and illegal opcodes are screened without using the ALU. Each ALU wait is bounded by TIMEOUT.
//
// Opcode map: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR; 8..15 are illegal.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   start, abort                run request (IDLE only) / synchronous abort (non-IDLE only)
//   first_addr, last_addr       inclusive range bounds, latched on accepted start
//   busy, done, exec_count      run status
//   flag_div0/ill/ovf/tmo       sticky status, cleared on accepted start or reset
//   rd_addr, rd_opc/op_a/op_b   instruction register read; data valid the following cycle
//   alu_valid/ready/opc/a/b     ALU issue handshake
//   alu_res_valid, alu_result   ALU result return (64-bit signed)
//   wr_en, wr_addr, wr_result   result write-back
module instr_exec_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  output logic        busy,
  output logic        done,
  output logic [5:0]  exec_count,
  output logic        flag_div0,
  output logic        flag_ill,
  output logic        flag_ovf,
  output logic        flag_tmo,
  output logic [4:0]  rd_addr,
  input  logic [3:0]  rd_opc,
  input  logic [31:0] rd_op_a,
  input  logic [31:0] rd_op_b,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [3:0]  alu_opc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_res_valid,
  input  logic [63:0] alu_result,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_result
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StIssue = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StWrite = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpMod = 4'd4;
  localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [4:0]  cur_q, cur_d, end_q, end_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div0_q, div0_d, ill_q, ill_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [3:0]  opc_q, opc_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        res_fits;

  // Representable as signed 32-bit only if bits 63..31 are all copies of the sign.
  assign res_fits = (&alu_result[63:31]) || !(|alu_result[63:31]);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    cnt_d     = cnt_q;
    div0_d    = div0_q;
    ill_d     = ill_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    opc_d     = opc_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    tmo_cnt_d = tmo_cnt_q;

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cur_d   = first_addr;
            end_d   = last_addr;
            cnt_d   = '0;
            div0_d  = 1'b0;
            ill_d   = 1'b0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
            state_d = StFetch;
          end
        end
        StFetch: state_d = StCheck;
        StCheck: begin
          opc_d = rd_opc;
          a_d   = rd_op_a;
          b_d   = rd_op_b;
          if (rd_opc[3]) begin
            ill_d   = 1'b1;
            res_d   = '0;
            state_d = StWrite;
          end else if (((rd_opc == OpDiv) || (rd_opc == OpMod)) && (rd_op_b == '0)) begin
            div0_d  = 1'b1;
            res_d   = '0;
            state_d = StWrite;
          end else begin
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (alu_ready) begin
            tmo_cnt_d = '0;
            state_d   = StWait;
          end
        end
        StWait: begin
          if (alu_res_valid) begin
            res_d = alu_result[31:0];
            if (!res_fits) ovf_d = 1'b1;
            state_d = StWrite;
          end else if (tmo_cnt_q == TmoLimit) begin
            tmo_d   = 1'b1;
            res_d   = '0;
            state_d = StWrite;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
        StWrite: begin
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + 5'd1;  // 31 wraps to 0
            state_d = StFetch;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // wr_en is already high during WRITE, so the write is counted even if abort arrives with it.
    if (state_q == StWrite) cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      div0_q    <= 1'b0;
      ill_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      cnt_q     <= cnt_d;
      div0_q    <= div0_d;
      ill_q     <= ill_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      opc_q     <= opc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign exec_count = cnt_q;
  assign flag_div0  = div0_q;
  assign flag_ill   = ill_q;
  assign flag_ovf   = ovf_q;
  assign flag_tmo   = tmo_q;
  assign rd_addr    = cur_q;
  assign alu_valid  = (state_q == StIssue);
  assign alu_opc    = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign wr_en      = (state_q == StWrite);
  assign wr_addr    = cur_q;
  assign wr_result  = res_q;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Testbench for instr_exec_sequencer: instruction register and ALU models, a write-back
// scoreboard, a table of single-instruction vectors and hand-written multi-cycle sequences.
module tb_instr_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [4:0]  first_addr, last_addr;
  logic        busy, done;
  logic [5:0]  exec_count;
  logic        flag_div0, flag_ill, flag_ovf, flag_tmo;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_opc;
  logic [31:0] rd_op_a, rd_op_b;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_opc;
  logic [31:0] alu_a, alu_b;
  logic        alu_res_valid;
  logic [63:0] alu_result;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_result;

  always #5 clk = ~clk;

  instr_exec_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .exec_count(exec_count),
    .flag_div0(flag_div0), .flag_ill(flag_ill), .flag_ovf(flag_ovf), .flag_tmo(flag_tmo),
    .rd_addr(rd_addr), .rd_opc(rd_opc), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opc(alu_opc),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_res_valid(alu_res_valid), .alu_result(alu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_result(wr_result)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Signed ALU reference: operands sign-extended, full 64-bit result.
  function automatic logic [63:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      4'd0: r = sa + sb;
      4'd1: r = sa - sb;
      4'd2: r = sa * sb;
      4'd3: r = (sb == 0) ? 64'sd0 : sa / sb;
      4'd4: r = (sb == 0) ? 64'sd0 : sa % sb;
      4'd5: r = sa & sb;
      4'd6: r = sa | sb;
      4'd7: r = sa ^ sb;
      default: r = 64'sd0;
    endcase
    return r;
  endfunction

  // Instruction register model: one-cycle read latency.
  logic [3:0]  m_opc [32];
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  always @(posedge clk) begin
    rd_opc  <= m_opc[rd_addr];
    rd_op_a <= m_a[rd_addr];
    rd_op_b <= m_b[rd_addr];
  end

  // ALU model: ready after stall_cycles of continuous valid; result one cycle after transfer.
  int   stall_cycles = 0;
  int   valid_run = 0;
  logic no_resp = 1'b0;
  int   xfer_cnt = 0;
  assign alu_ready = (valid_run >= stall_cycles);
  always @(posedge clk) begin
    alu_res_valid <= 1'b0;
    valid_run <= alu_valid ? valid_run + 1 : 0;
    if (alu_valid && alu_ready) begin
      xfer_cnt++;
      valid_run <= 0;
      if (!no_resp) begin
        alu_res_valid <= 1'b1;
        alu_result    <= alu_calc(alu_opc, alu_a, alu_b);
      end
    end
  end

  // Write-back scoreboard.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t  sbq[$];
  logic model_ovf;

  always @(negedge clk) begin
    if (wr_en) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wr: got addr=%0d data=%0h, expected no write", wr_addr,
                 wr_result);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_result", 64'(wr_result), 64'(e.data));
      end
    end
  end

  // Operand stability monitor while alu_valid is high.
  logic        track_alu = 1'b0;
  int          valid_cycles = 0;
  logic [3:0]  exp_opc;
  logic [31:0] exp_a, exp_b;
  always @(negedge clk) begin
    if (track_alu && alu_valid) begin
      valid_cycles++;
      chk("alu_opc_stable", 64'(alu_opc), 64'(exp_opc));
      chk("alu_a_stable", 64'(alu_a), 64'(exp_a));
      chk("alu_b_stable", 64'(alu_b), 64'(exp_b));
    end
  end

  task automatic push_exp(input logic [4:0] ad, input logic [31:0] data);
    wr_t e;
    e.addr = ad;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic push_model(input logic [4:0] ad);
    logic [63:0] r;
    logic [32:0] hi;
    if (m_opc[ad] > 4'd7) begin
      push_exp(ad, 32'd0);
    end else if ((m_opc[ad] == 4'd3 || m_opc[ad] == 4'd4) && m_b[ad] == 32'd0) begin
      push_exp(ad, 32'd0);
    end else begin
      r  = alu_calc(m_opc[ad], m_a[ad], m_b[ad]);
      hi = r[63:31];
      if (hi != '0 && hi != '1) model_ovf = 1'b1;
      push_exp(ad, r[31:0]);
    end
  endtask

  // Returns at the negedge of cycle 1 (start accepted at the preceding edge).
  task automatic start_run(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [4:0] f, input logic [4:0] l, input int budget,
                     output int dcyc);
    int cyc;
    start_run(f, l);
    cyc  = 1;
    dcyc = -1;
    chk("busy_cycle1", 64'(busy), 64'd1);
    while (cyc <= budget) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (dcyc >= 0) begin
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_exec_count", 64'(exec_count), 64'd0);
    chk("rst_flags", 64'({flag_div0, flag_ill, flag_ovf, flag_tmo}), 64'd0);
    chk("rst_alu_valid", 64'(alu_valid), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_alu_opc", 64'(alu_opc), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_wr_result", 64'(wr_result), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] a, b, res;
    logic        div0, ill, ovf;
    int          lat;
  } vec_t;
  vec_t vec [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, base, saw;
    vec[0]  = '{4'd0, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 6};
    vec[1]  = '{4'd1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 6};
    vec[2]  = '{4'd2, 32'h40000000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 6};
    vec[3]  = '{4'd3, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4};
    vec[4]  = '{4'd4, 32'd7, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, 6};
    vec[5]  = '{4'd9, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 4};
    vec[6]  = '{4'd3, 32'hFFFFFFF7, 32'd2, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 6};
    vec[7]  = '{4'd4, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4};
    vec[8]  = '{4'd2, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 6};
    vec[9]  = '{4'd7, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 6};
    vec[10] = '{4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4};
    vec[11] = '{4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1'b1, 6};

    for (int i = 0; i < 32; i++) begin
      m_opc[i] = 4'd0;
      m_a[i]   = 32'd0;
      m_b[i]   = 32'd0;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; first_addr = '0; last_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_values();

    // Single-instruction table; entry i lives at address i+3 (ADD 5,-7 at entry 3).
    for (int i = 0; i < 12; i++) begin
      logic [4:0] ad;
      ad = 5'(i + 3);
      m_opc[ad] = vec[i].opc;
      m_a[ad]   = vec[i].a;
      m_b[ad]   = vec[i].b;
      push_exp(ad, vec[i].res);
      run(ad, ad, 60, dc);
      chk($sformatf("v%0d_done_latency", i), 64'(dc), 64'(vec[i].lat));
      chk($sformatf("v%0d_exec_count", i), 64'(exec_count), 64'd1);
      chk($sformatf("v%0d_flags", i), 64'({flag_div0, flag_ill, flag_ovf, flag_tmo}),
          64'({vec[i].div0, vec[i].ill, vec[i].ovf, 1'b0}));
      chk($sformatf("v%0d_sb_drained", i), 64'(sbq.size()), 64'd0);
    end

    // Faults and overflow in one run: only MULT and MOD reach the ALU.
    m_opc[0] = 4'd3; m_a[0] = 32'd5;          m_b[0] = 32'd0;
    m_opc[1] = 4'd9; m_a[1] = 32'd1;          m_b[1] = 32'd2;
    m_opc[2] = 4'd2; m_a[2] = 32'h40000000;   m_b[2] = 32'd4;
    m_opc[3] = 4'd4; m_a[3] = 32'd7;          m_b[3] = 32'd3;
    push_exp(5'd0, 32'd0); push_exp(5'd1, 32'd0);
    push_exp(5'd2, 32'd0); push_exp(5'd3, 32'd1);
    base = xfer_cnt;
    run(5'd0, 5'd3, 100, dc);
    chk("fault_done_latency", 64'(dc), 64'd17);
    chk("fault_flags", 64'({flag_div0, flag_ill, flag_ovf, flag_tmo}), 64'b1110);
    chk("fault_alu_xfers", 64'(xfer_cnt - base), 64'd2);
    chk("fault_exec_count", 64'(exec_count), 64'd4);

    // Wrap-around 30..1.
    for (int i = 0; i < 32; i++) begin
      m_opc[i] = 4'd0;
      m_a[i]   = 32'(i);
      m_b[i]   = 32'd100;
    end
    push_model(5'd30); push_model(5'd31); push_model(5'd0); push_model(5'd1);
    run(5'd30, 5'd1, 100, dc);
    chk("wrap_done_latency", 64'(dc), 64'd21);
    chk("wrap_exec_count", 64'(exec_count), 64'd4);
    chk("wrap_sb_drained", 64'(sbq.size()), 64'd0);

    // Full range 5..4 with random healthy instructions.
    for (int i = 0; i < 32; i++) begin
      m_opc[i] = 4'($urandom_range(0, 7));
      m_a[i]   = $urandom;
      m_b[i]   = $urandom | 32'd1;
    end
    model_ovf = 1'b0;
    for (int i = 0; i < 32; i++) push_model(5'(5 + i));
    run(5'd5, 5'd4, 400, dc);
    chk("full_done_latency", 64'(dc), 64'd161);
    chk("full_exec_count", 64'(exec_count), 64'd32);
    chk("full_flag_ovf", 64'(flag_ovf), 64'(model_ovf));
    chk("full_sb_drained", 64'(sbq.size()), 64'd0);

    // ALU backpressure: ready low for 7 cycles of valid.
    m_opc[7] = 4'd1; m_a[7] = 32'h12345678; m_b[7] = 32'h00001111;
    exp_opc = 4'd1; exp_a = 32'h12345678; exp_b = 32'h00001111;
    push_model(5'd7);
    stall_cycles = 7; track_alu = 1'b1; valid_cycles = 0; base = xfer_cnt;
    run(5'd7, 5'd7, 60, dc);
    track_alu = 1'b0; stall_cycles = 0;
    chk("stall_valid_cycles", 64'(valid_cycles), 64'd8);
    chk("stall_alu_xfers", 64'(xfer_cnt - base), 64'd1);
    chk("stall_done_latency", 64'(dc), 64'd13);

    // Timeout: no ALU response.
    m_opc[9] = 4'd0; m_a[9] = 32'd1; m_b[9] = 32'd2;
    push_exp(5'd9, 32'd0);
    no_resp = 1'b1;
    run(5'd9, 5'd9, 60, dc);
    no_resp = 1'b0;
    chk("tmo_done_latency", 64'(dc), 64'd22);
    chk("tmo_flags", 64'({flag_div0, flag_ill, flag_ovf, flag_tmo}), 64'b0001);
    chk("tmo_exec_count", 64'(exec_count), 64'd1);

    // Abort in WAIT of the 3rd of 8 instructions (cycle 14).
    for (int i = 0; i < 8; i++) begin
      m_opc[i] = 4'd0;
      push_model(5'(i));
    end
    start_run(5'd0, 5'd7);
    repeat (12) @(negedge clk);
    chk("abort_pre_issue", 64'(alu_valid), 64'd1);
    @(negedge clk);
    chk("abort_in_wait", 64'({busy, alu_valid, wr_en}), 64'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_exec_count", 64'(exec_count), 64'd2);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || wr_en || busy) saw++;
      @(negedge clk);
    end
    chk("abort_quiet", 64'(saw), 64'd0);
    chk("abort_sb_left", 64'(sbq.size()), 64'd6);
    sbq.delete();

    // Reset in ISSUE after a faulted entry has set flag_ill and been counted.
    m_opc[0] = 4'd9; m_opc[1] = 4'd0; m_a[1] = 32'd2; m_b[1] = 32'd3;
    push_model(5'd0); push_model(5'd1);
    start_run(5'd0, 5'd1);
    repeat (5) @(negedge clk);
    chk("rstmid_in_issue", 64'({alu_valid, alu_a}), 64'({1'b1, 32'd2}));
    chk("rstmid_pre_state", 64'({flag_ill, exec_count}), 64'({1'b1, 6'd1}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values();
    chk("rstmid_sb_left", 64'(sbq.size()), 64'd1);
    sbq.delete();
    repeat (3) @(negedge clk);
    chk("rstmid_idle", 64'({busy, wr_en}), 64'd0);

    // Normal run after reset.
    m_opc[3] = 4'd0; m_a[3] = 32'd5; m_b[3] = 32'hFFFFFFF9;
    push_exp(5'd3, 32'hFFFFFFFE);
    run(5'd3, 5'd3, 60, dc);
    chk("post_done_latency", 64'(dc), 64'd6);
    chk("post_exec_count", 64'(exec_count), 64'd1);
    chk("post_flags", 64'({flag_div0, flag_ill, flag_ovf, flag_tmo}), 64'd0);
    chk("post_sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
